// File: rtl/cosim_commit_queue.sv
// rtl/cosim_commit_queue.sv - retire-to-cosim commit record FIFO with registered output stage
// Optional feature: define COSIM_X0_FILTER_EN to suppress register writes to x0.
module cosim_commit_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        retire_valid,
    input  logic [63:0] retire_pc,
    input  logic [31:0] retire_inst,
    input  logic        retire_we,
    input  logic [4:0]  retire_rd,
    input  logic [63:0] retire_wdata,
    input  logic        drain_en,
    output logic        cosim_valid,
    output logic [63:0] cosim_pc,
    output logic [31:0] cosim_inst,
    output logic        cosim_we,
    output logic [4:0]  cosim_rd,
    output logic [63:0] cosim_wdate,
    output logic        full,
    output logic        overflow,
    output logic [63:0] retire_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = 64 + 32 + 1 + 5 + 64;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             is_full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             we_in;
    logic [REC_W-1:0] rec_in;

`ifdef COSIM_X0_FILTER_EN
    assign we_in = retire_we && (retire_rd != 5'd0);
`else
    assign we_in = retire_we;
`endif

    assign is_full = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign full    = is_full;
    // A pop frees the slot being written on a full queue; an empty queue never pops.
    assign pop     = drain_en && !empty;
    assign push    = retire_valid && (!is_full || pop);
    assign rec_in  = {retire_pc, retire_inst, we_in, retire_rd, retire_wdata};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rec_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            retire_count <= '0;
        end else begin
            if (push) begin
                wr_ptr       <= wr_ptr + PTR_W'(1);
                retire_count <= retire_count + 64'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (retire_valid && is_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output stage is zeroed on idle cycles so the checker never sees stale fields.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cosim_valid <= 1'b0;
            cosim_pc    <= '0;
            cosim_inst  <= '0;
            cosim_we    <= 1'b0;
            cosim_rd    <= '0;
            cosim_wdate <= '0;
        end else if (pop) begin
            cosim_valid <= 1'b1;
            {cosim_pc, cosim_inst, cosim_we, cosim_rd, cosim_wdate} <= mem[rd_ptr];
        end else begin
            cosim_valid <= 1'b0;
            cosim_pc    <= '0;
            cosim_inst  <= '0;
            cosim_we    <= 1'b0;
            cosim_rd    <= '0;
            cosim_wdate <= '0;
        end
    end
endmodule
